// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: command encodings, FSM states, frame sizes.
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RW,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;

    // Longest stay (in clocks) in any single FSM state; sizes the shared state counter.
    function automatic int unsigned cnt_span(input int unsigned turn_cycles,
                                             input int unsigned idle_gap);
        int unsigned m;
        m = FRAME_BITS;
        if (DATA_BITS > m)   m = DATA_BITS;
        if (turn_cycles > m) m = turn_cycles;
        if (idle_gap > m)    m = idle_gap;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// MOSI parallel-in/serial-out frame register and MISO serial-in/parallel-out receive register.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_out,
    input  logic                  shift_in,
    input  logic [FRAME_BITS-1:0] frame_in,
    input  logic                  miso,
    output logic                  mosi_bit,
    output logic [DATA_BITS-1:0]  rx_byte
);

    logic [FRAME_BITS-1:0] tx_q;
    logic [DATA_BITS-2:0]  rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (load)
                tx_q <= frame_in;
            else if (shift_out)
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            if (shift_in)
                rx_q <= rx_byte[DATA_BITS-2:0];
        end
    end

    assign mosi_bit = tx_q[FRAME_BITS-1];
    // The live MISO bit completes the byte, so the final sample is usable on the edge it arrives.
    assign rx_byte  = {rx_q, miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: turns one {cmd, din} host request into a slave frame and returns read data.
// Optional SPI_MASTER_SEQ_CHECK_EN adds seq_err for RD_DATA issued before any RD_ADDR frame.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned IDLE_GAP    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [7:0]           din,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    output logic                 seq_err
`endif
);

    localparam int unsigned CNT_W = $clog2(cnt_span(TURN_CYCLES, IDLE_GAP));
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    cmd_t                 cmd_q;
    logic                 load, shift_out, shift_in, frame_end;
    logic                 mosi_bit;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 ss_n_d, mosi_d, busy_d, done_d, rdata_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cmd_q <= CMD_WR_ADDR;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
            if (load)
                cmd_q <= cmd_t'(cmd);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SELECT;
            SELECT:  next_state = RW;
            RW:      next_state = SHIFT;
            SHIFT:   if (cnt == SHIFT_LAST)
                         next_state = (cmd_q == CMD_RD_DATA) ? TURN : GAP;
            TURN:    if (cnt == TURN_LAST) next_state = RECV;
            RECV:    if (cnt == RECV_LAST) next_state = GAP;
            GAP:     if (cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed from next_state so the registered pins line up with the state they describe.
    always_comb begin
        load          = (state == IDLE) && start;
        shift_out     = (next_state == SHIFT);
        shift_in      = (state == RECV);
        frame_end     = (next_state == GAP) && (state != GAP);
        ss_n_d        = (next_state == IDLE) || (next_state == GAP);
        mosi_d        = ((next_state == RW) || (next_state == SHIFT)) ? mosi_bit : 1'b0;
        busy_d        = (next_state != IDLE);
        done_d        = frame_end;
        rdata_valid_d = frame_end && (cmd_q == CMD_RD_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n        <= 1'b1;
            MOSI        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
        end else begin
            SS_n        <= ss_n_d;
            MOSI        <= mosi_d;
            busy        <= busy_d;
            done        <= done_d;
            rdata_valid <= rdata_valid_d;
            if (rdata_valid_d)
                rdata <= rx_byte;
        end
    end

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_addr_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_seen <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            if (frame_end && (cmd_q == CMD_RD_ADDR))
                rd_addr_seen <= 1'b1;
            if (load && (cmd_t'(cmd) == CMD_RD_DATA) && !rd_addr_seen)
                seq_err <= 1'b1;
        end
    end
`endif

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift_out (shift_out),
        .shift_in  (shift_in),
        .frame_in  ({cmd, din}),
        .miso      (MISO),
        .mosi_bit  (mosi_bit),
        .rx_byte   (rx_byte)
    );

endmodule
